md5_digest_checker: RTL and testbench
=====================================

# md5_digest_checker

Downstream consumer of the 32-slot MD5 digest array. Watches the per-slot `done` bits, reads each finished 128-bit digest one 32-bit word at a time through the array's `readaddr`/`readdata` port, and compares it against a programmable 128-bit target. It queues the indices of matching slots in a 4-entry FIFO for the host, and pulses the slot's reset so the slot can be reloaded.

## Interface
Parameters: none; widths are fixed to the 32-slot, 4-word array.

- `clk` in 1: system clock; all state rises on this edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `target_write` in 1: write strobe for the target register.
- `target_addr` in 2: target word select; word w holds digest bits [32w+31:32w].
- `target_data` in 32: target word value.
- `done` in 32: per-slot digest-ready flags from the digest array.
- `readaddr` out 7: {slot[4:0], word[1:0]} to the digest array; registered.
- `readdata` in 32: digest word from the array; combinational from `readaddr`, valid in the same cycle.
- `clear` out 32: one-cycle reset pulse per slot; drives the array's per-slot reset bus.
- `busy` out 1: high when not in IDLE.
- `match_empty` out 1: FIFO empty.
- `match_index` out 5: slot index at the FIFO head; holds the last value when the FIFO is empty.
- `match_pop` in 1: dequeue the head; ignored when empty.
- `overflow` out 1: sticky; set when a match is dropped because the FIFO is full.
- `checked_count` out 16: number of digests checked; wraps at 2^16.

## Operation
- The target register is 4×32 bits.
  - A write is accepted only when `busy`=0. Writes while busy are ignored.
  - Reset value is 0.
- Masks:
  - `pending` = `done` & ~`retire`.
  - `retire[i]` is set with `clear[i]`. It is cleared on any cycle where `done[i]`=0. This prevents re-checking a slot whose `done` has not yet dropped.
- IDLE:
  - If `pending`≠0, select the first set bit at or above `rr_ptr`, wrapping from 31 to 0.
  - Latch it as `cur`, drive `readaddr`={cur,2'b00}, set `eq`=1, and go to SCAN with w=0.
- SCAN (4 cycles, w=0..3):
  - Each cycle, `eq` &= (`readdata` == target[w]).
  - `readaddr` advances to {cur,w+1}.
  - After w=3, go to RESULT.
- RESULT (1 cycle):
  - `clear[cur]`=1 and `retire[cur]`=1.
  - `checked_count`++.
  - `rr_ptr` = cur+1 mod 32.
  - If `eq`: push `cur` to the FIFO. If the FIFO is full and there is no simultaneous pop, drop the entry and set `overflow`.
  - Go to IDLE.
- FIFO: 4 entries with 2-bit wrapping read/write pointers and a 3-bit count.
  - Simultaneous push and pop is legal at any fill level, including full: the pop frees the slot and the push lands, leaving count unchanged.
- `readaddr` in IDLE with nothing pending holds its previous value.
- Reset mid-scan returns to IDLE immediately. No `clear` pulse is emitted and the in-flight digest is not counted.
- Reset values: `readaddr`=0, `clear`=0, `busy`=0, `match_empty`=1, `match_index`=0, `overflow`=0, `checked_count`=0, `rr_ptr`=0, `retire`=0.

## Timing
- Cycle n (IDLE): `pending` is seen and the slot is selected.
- Cycles n+1..n+4: words 0..3 are compared.
- Cycle n+5: `clear` pulse; the match is pushed.
- Cycle n+6: back in IDLE.
- Throughput is one digest per 6 cycles.
- `match_empty` falls in the cycle after the push (n+6).
- A pop takes effect at the next edge: `match_index` shows the next entry one cycle later.
- `clear` is exactly one cycle wide, driven from a register (glitch-free).
- A `done` bit rising during a scan of a different slot is served after that scan completes, in round-robin order.

## Test plan
- Target = 0x0123…CDEF. Set `done[5]`=1 with a matching digest in slot 5 → `readaddr` steps 0x14, 0x15, 0x16, 0x17; `clear`=0x20 at n+5; `match_index`=5; `match_empty`=0; `checked_count`=1.
- Slot 5 digest differs only in word 3 → `clear[5]` pulses; FIFO stays empty; `checked_count`=1.
- `done`=0xFFFFFFFF, all digests matching, no pops → slots checked in order 0..31. FIFO holds 0,1,2,3. `overflow`=1 after slot 4. `checked_count`=32 after 192 cycles.
- `rr_ptr`=10 and `done` bits {3,12} set together → slot 12 is served before slot 3.
- Hold `done[7]` high for 3 cycles after `clear[7]` → slot 7 is not re-checked. Drop `done[7]`, then raise it again → slot 7 is re-checked.
- Assert `reset` at the 3rd SCAN cycle → all outputs return to their reset values. No `clear` pulse occurs, and the next `done` restarts from IDLE.

Source files
------------

// File: rtl/md5_digest_checker.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// md5_digest_checker
//
// Consumer of the 32-slot MD5 digest array. Picks finished slots in
// round-robin order, reads their 128-bit digest one 32-bit word per cycle
// and compares it with a programmable target. Matching slot indices are
// queued in a 4-entry FIFO for the host. Every checked slot gets a
// one-cycle reset pulse so the array can reload it.
//
// Ports
//   clk            system clock, all state on rising edge
//   reset          asynchronous active-high reset
//   target_write   target word write strobe (accepted only while idle)
//   target_addr    target word select, word w = digest bits [32w+31:32w]
//   target_data    target word value
//   done           per-slot digest-ready flags from the array
//   readaddr       {slot, word} read address to the array (registered)
//   readdata       digest word from the array, combinational from readaddr
//   clear          one-cycle per-slot reset pulse to the array (registered)
//   busy           high whenever the checker is not idle
//   match_empty    match FIFO empty
//   match_index    slot index at the FIFO head (holds last value when empty)
//   match_pop      dequeue the FIFO head, ignored when empty
//   overflow       sticky, a match was dropped because the FIFO was full
//   checked_count  number of digests checked, wraps at 2^16
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for a pending slot; picks the next one round-robin
// ST_SCAN   | comparing digest words 0..3 of the current slot, one per cycle
// ST_RESULT | clear pulse out, count/FIFO updated, round-robin pointer moves
// ----------------------------------------------------------------------------
module md5_digest_checker (
    input  logic        clk,
    input  logic        reset,
    input  logic        target_write,
    input  logic [1:0]  target_addr,
    input  logic [31:0] target_data,
    input  logic [31:0] done,
    output logic [6:0]  readaddr,
    input  logic [31:0] readdata,
    output logic [31:0] clear,
    output logic        busy,
    output logic        match_empty,
    output logic [4:0]  match_index,
    input  logic        match_pop,
    output logic        overflow,
    output logic [15:0] checked_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        word_q, word_d;
    logic [4:0]        cur_q, cur_d;
    logic              eq_q, eq_d;
    logic [6:0]        readaddr_q, readaddr_d;
    logic [31:0]       clear_q, clear_d;
    logic [31:0]       retire_q, retire_d;
    logic [4:0]        rr_ptr_q, rr_ptr_d;
    logic [15:0]       checked_count_q, checked_count_d;
    logic              overflow_q, overflow_d;
    logic [3:0][31:0]  target_q, target_d;

    logic [3:0][4:0]   fifo_mem_q, fifo_mem_d;
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q, count_d;
    logic [4:0]        match_index_q, match_index_d;

    logic [31:0]       pending;
    logic              sel_hit;
    logic [4:0]        sel_idx;
    logic              push;
    logic              push_ok;
    logic              pop_en;

    // Round-robin pick: first pending slot at or above rr_ptr, wrapping 31->0.
    always_comb begin
        pending = done & ~retire_q;
        sel_hit = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < 32; k++) begin
            if (!sel_hit && pending[rr_ptr_q + 5'(k)]) begin
                sel_hit = 1'b1;
                sel_idx = rr_ptr_q + 5'(k);
            end
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d         = state_q;
        word_d          = word_q;
        cur_d           = cur_q;
        eq_d            = eq_q;
        readaddr_d      = readaddr_q;
        clear_d         = '0;
        rr_ptr_d        = rr_ptr_q;
        checked_count_d = checked_count_q;
        push            = 1'b0;
        target_d        = target_q;

        if (target_write && (state_q == ST_IDLE)) begin
            target_d[target_addr] = target_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_hit) begin
                    cur_d      = sel_idx;
                    readaddr_d = {sel_idx, 2'b00};
                    eq_d       = 1'b1;
                    word_d     = 2'd0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                eq_d       = eq_q & (readdata == target_q[word_q]);
                word_d     = word_q + 2'd1;
                readaddr_d = {cur_q, word_q + 2'd1};
                if (word_q == 2'd3) begin
                    // clear is registered so the pulse lands exactly in RESULT
                    clear_d = 32'd1 << cur_q;
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                checked_count_d = checked_count_q + 16'd1;
                rr_ptr_d        = cur_q + 5'd1;
                push            = eq_q;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A retired slot stays masked until its done flag drops once.
        retire_d = (retire_q | clear_d) & done;
    end

    // Match FIFO; a pop frees a slot for a same-cycle push even when full.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;

        pop_en  = match_pop && (count_q != 3'd0);
        push_ok = push && ((count_q != 3'd4) || pop_en);

        if (push_ok) begin
            fifo_mem_d[wr_ptr_q] = cur_q;
            wr_ptr_d             = wr_ptr_q + 2'd1;
        end else if (push) begin
            overflow_d = 1'b1;
        end

        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        count_d = count_q + {2'b00, push_ok} - {2'b00, pop_en};

        // Head is registered so it can hold its last value once empty.
        match_index_d = (count_d != 3'd0) ? fifo_mem_d[rd_ptr_d] : match_index_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            word_q          <= '0;
            cur_q           <= '0;
            eq_q            <= 1'b0;
            readaddr_q      <= '0;
            clear_q         <= '0;
            retire_q        <= '0;
            rr_ptr_q        <= '0;
            checked_count_q <= '0;
            overflow_q      <= 1'b0;
            target_q        <= '0;
            fifo_mem_q      <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            match_index_q   <= '0;
        end else begin
            state_q         <= state_d;
            word_q          <= word_d;
            cur_q           <= cur_d;
            eq_q            <= eq_d;
            readaddr_q      <= readaddr_d;
            clear_q         <= clear_d;
            retire_q        <= retire_d;
            rr_ptr_q        <= rr_ptr_d;
            checked_count_q <= checked_count_d;
            overflow_q      <= overflow_d;
            target_q        <= target_d;
            fifo_mem_q      <= fifo_mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            match_index_q   <= match_index_d;
        end
    end

    assign readaddr      = readaddr_q;
    assign clear         = clear_q;
    assign busy          = (state_q != ST_IDLE);
    assign match_empty   = (count_q == 3'd0);
    assign match_index   = match_index_q;
    assign overflow      = overflow_q;
    assign checked_count = checked_count_q;

endmodule

// File: tb/tb_md5_digest_checker.sv
`timescale 1ns/1ps
// Testbench for md5_digest_checker: directed sequences, a vector table and
// randomized batches checked against a queue-based reference model.
module tb_md5_digest_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        target_write;
    logic [1:0]  target_addr;
    logic [31:0] target_data;
    logic [31:0] done;
    logic [6:0]  readaddr;
    logic [31:0] readdata;
    logic [31:0] clear;
    logic        busy;
    logic        match_empty;
    logic [4:0]  match_index;
    logic        match_pop;
    logic        overflow;
    logic [15:0] checked_count;

    md5_digest_checker dut (
        .clk           (clk),
        .reset         (reset),
        .target_write  (target_write),
        .target_addr   (target_addr),
        .target_data   (target_data),
        .done          (done),
        .readaddr      (readaddr),
        .readdata      (readdata),
        .clear         (clear),
        .busy          (busy),
        .match_empty   (match_empty),
        .match_index   (match_index),
        .match_pop     (match_pop),
        .overflow      (overflow),
        .checked_count (checked_count)
    );

    always #5 clk = ~clk;

    // Digest array model: combinational read.
    logic [31:0] dig [32][4];
    logic [31:0] tgt [4];
    assign readdata = dig[readaddr[6:2]][readaddr[1:0]];

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt;

    // Reference model state for the random phase
    int   q_model[$];
    int   exp_order[$];
    int   last_head;
    int   exp_ovf;
    int   pop_prob;
    logic is_match [32];

    typedef struct {
        int       slot;
        logic [3:0] flip;
        logic     exp_match;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_digest(input int s, input logic [3:0] flip);
        for (int w = 0; w < 4; w++)
            dig[s][w] = flip[w] ? (tgt[w] ^ ($urandom() | 32'h1)) : tgt[w];
    endtask

    task automatic write_target();
        for (int w = 0; w < 4; w++) begin
            target_write = 1'b1;
            target_addr  = 2'(w);
            target_data  = tgt[w];
            @(negedge clk);
        end
        target_write = 1'b0;
    endtask

    task automatic wait_clear(output logic [31:0] seen, input int budget);
        seen = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (clear != 0) begin
                seen = clear;
                break;
            end
        end
    endtask

    task automatic expect_no_clear(input string name, input int cycles);
        int hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (clear != 0) hits++;
        end
        check(name, 32'(hits), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && match_empty == 1'b0; i++) begin
            match_pop = 1'b1;
            @(negedge clk);
        end
        match_pop = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_readaddr"},      32'(readaddr), 32'd0);
        check({tag, "_clear"},         clear, 32'd0);
        check({tag, "_busy"},          32'(busy), 32'd0);
        check({tag, "_match_empty"},   32'(match_empty), 32'd1);
        check({tag, "_match_index"},   32'(match_index), 32'd0);
        check({tag, "_overflow"},      32'(overflow), 32'd0);
        check({tag, "_checked_count"}, 32'(checked_count), 32'd0);
    endtask

    // One cycle of the random phase: compare, then decide stimulus.
    task automatic rand_cycle();
        int s;
        @(negedge clk);
        check("rnd_match_empty",   32'(match_empty), 32'(q_model.size() == 0));
        check("rnd_match_index",   32'(match_index), 32'(last_head));
        check("rnd_overflow",      32'(overflow), 32'(exp_ovf));
        check("rnd_checked_count", 32'(checked_count), 32'(exp_cnt & 16'hFFFF));
        match_pop = 1'b0;
        if (q_model.size() > 0 && pop_prob != 0 && $urandom_range(1, 4) <= 32'(pop_prob)) begin
            match_pop = 1'b1;
            void'(q_model.pop_front());
        end
        if (clear != 0) begin
            if (exp_order.size() == 0) begin
                check("rnd_unexpected_clear", clear, 32'd0);
            end else begin
                s = exp_order.pop_front();
                check("rnd_clear_slot", clear, 32'd1 << s);
                done[s] = 1'b0;
                exp_cnt++;
                if (is_match[s]) begin
                    if (q_model.size() < 4) q_model.push_back(s);
                    else exp_ovf = 1;
                end
            end
        end
        if (q_model.size() > 0) last_head = q_model[0];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seen;
        int cyc, nclr, first32, rr, last, budget;
        logic [31:0] mask;

        reset        = 1'b1;
        done         = '0;
        match_pop    = 1'b0;
        target_write = 1'b0;
        target_addr  = '0;
        target_data  = '0;
        pop_prob     = 0;
        for (int s = 0; s < 32; s++)
            for (int w = 0; w < 4; w++) dig[s][w] = '0;
        tgt[0] = 32'h89ABCDEF;
        tgt[1] = 32'h01234567;
        tgt[2] = 32'h89ABCDEF;
        tgt[3] = 32'h01234567;

        @(negedge clk);
        @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        @(negedge clk);
        write_target();
        exp_cnt = 0;

        // Matching digest in slot 5: address stepping and result timing
        set_digest(5, 4'b0000);
        done[5] = 1'b1;
        @(negedge clk); check("t1_addr0", 32'(readaddr), 32'h14);
        @(negedge clk); check("t1_addr1", 32'(readaddr), 32'h15);
        @(negedge clk); check("t1_addr2", 32'(readaddr), 32'h16);
        @(negedge clk); check("t1_addr3", 32'(readaddr), 32'h17);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk); check("t1_clear", clear, 32'h20);
        check("t1_empty_at_push", 32'(match_empty), 32'd1);
        done[5] = 1'b0;
        exp_cnt++;
        @(negedge clk);
        check("t1_clear_width", clear, 32'd0);
        check("t1_empty", 32'(match_empty), 32'd0);
        check("t1_index", 32'(match_index), 32'd5);
        check("t1_count", 32'(checked_count), 32'(exp_cnt));
        check("t1_idle", 32'(busy), 32'd0);
        drain();
        check("t1_drained", 32'(match_empty), 32'd1);

        // Slot 5 differs only in word 3
        set_digest(5, 4'b1000);
        done[5] = 1'b1;
        wait_clear(seen, 20);
        check("t2_clear", seen, 32'h20);
        done[5] = 1'b0;
        exp_cnt++;
        @(negedge clk);
        check("t2_empty", 32'(match_empty), 32'd1);
        check("t2_count", 32'(checked_count), 32'(exp_cnt));

        // Vector table
        tbl[0] = '{slot: 0,  flip: 4'b0000, exp_match: 1'b1};
        tbl[1] = '{slot: 31, flip: 4'b0000, exp_match: 1'b1};
        tbl[2] = '{slot: 17, flip: 4'b0001, exp_match: 1'b0};
        tbl[3] = '{slot: 8,  flip: 4'b0100, exp_match: 1'b0};
        tbl[4] = '{slot: 22, flip: 4'b0010, exp_match: 1'b0};
        tbl[5] = '{slot: 13, flip: 4'b0000, exp_match: 1'b1};
        for (int i = 0; i < 6; i++) begin
            set_digest(tbl[i].slot, tbl[i].flip);
            done[tbl[i].slot] = 1'b1;
            wait_clear(seen, 20);
            check($sformatf("tbl%0d_clear", i), seen, 32'd1 << tbl[i].slot);
            done[tbl[i].slot] = 1'b0;
            exp_cnt++;
            @(negedge clk);
            check($sformatf("tbl%0d_empty", i), 32'(match_empty), 32'(!tbl[i].exp_match));
            if (tbl[i].exp_match)
                check($sformatf("tbl%0d_index", i), 32'(match_index), 32'(tbl[i].slot));
            check($sformatf("tbl%0d_count", i), 32'(checked_count), 32'(exp_cnt));
            drain();
        end

        // rr_ptr = 10, then slots 3 and 12 together: 12 first
        set_digest(9, 4'b0001);
        done[9] = 1'b1;
        wait_clear(seen, 20);
        check("rr_setup_clear", seen, 32'h200);
        done[9] = 1'b0;
        exp_cnt++;
        @(negedge clk);
        set_digest(3, 4'b0000);
        set_digest(12, 4'b0000);
        done[3]  = 1'b1;
        done[12] = 1'b1;
        wait_clear(seen, 20);
        check("rr_first", seen, 32'd1 << 12);
        done[12] = 1'b0;
        wait_clear(seen, 20);
        check("rr_second", seen, 32'd1 << 3);
        done[3] = 1'b0;
        exp_cnt += 2;
        @(negedge clk);
        check("rr_head", 32'(match_index), 32'd12);
        check("rr_count", 32'(checked_count), 32'(exp_cnt));
        drain();

        // done[7] held high after its clear: no re-check until it drops
        set_digest(7, 4'b0010);
        done[7] = 1'b1;
        wait_clear(seen, 20);
        check("hold_clear", seen, 32'h80);
        expect_no_clear("hold_no_recheck", 10);
        done[7] = 1'b0;
        @(negedge clk);
        done[7] = 1'b1;
        wait_clear(seen, 20);
        check("hold_recheck", seen, 32'h80);
        done[7] = 1'b0;
        exp_cnt += 2;
        @(negedge clk);
        check("hold_count", 32'(checked_count), 32'(exp_cnt));

        // Target write while busy is ignored
        set_digest(20, 4'b0000);
        done[20] = 1'b1;
        @(negedge clk);
        target_write = 1'b1;
        target_addr  = 2'd3;
        target_data  = ~tgt[3];
        @(negedge clk);
        target_write = 1'b0;
        wait_clear(seen, 20);
        check("busywr_clear", seen, 32'd1 << 20);
        done[20] = 1'b0;
        exp_cnt++;
        @(negedge clk);
        check("busywr_match", 32'(match_empty), 32'd0);
        drain();
        set_digest(21, 4'b0000);
        done[21] = 1'b1;
        wait_clear(seen, 20);
        done[21] = 1'b0;
        exp_cnt++;
        @(negedge clk);
        check("busywr_target_kept", 32'(match_empty), 32'd0);
        drain();

        // Fill FIFO, then push with a simultaneous pop at full
        for (int s = 24; s < 28; s++) begin
            set_digest(s, 4'b0000);
            done[s] = 1'b1;
        end
        for (int s = 24; s < 28; s++) begin
            wait_clear(seen, 20);
            check("full_fill_order", seen, 32'd1 << s);
            done[s] = 1'b0;
            exp_cnt++;
        end
        set_digest(28, 4'b0000);
        done[28] = 1'b1;
        wait_clear(seen, 20);
        check("full_push_clear", seen, 32'd1 << 28);
        done[28] = 1'b0;
        exp_cnt++;
        match_pop = 1'b1;
        @(negedge clk);
        match_pop = 1'b0;
        check("full_no_overflow", 32'(overflow), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("full_drain_empty", 32'(match_empty), 32'd0);
            check("full_drain_index", 32'(match_index), 32'(25 + k));
            match_pop = 1'b1;
            @(negedge clk);
            match_pop = 1'b0;
        end
        check("full_drained", 32'(match_empty), 32'd1);
        check("full_hold_index", 32'(match_index), 32'd28);
        check("full_count", 32'(checked_count), 32'(exp_cnt));

        // Reset during the third SCAN cycle
        set_digest(9, 4'b0000);
        done[9] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_addr", 32'(readaddr), 32'h26);
        reset   = 1'b1;
        done[9] = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        expect_no_clear("rst_no_clear", 8);
        write_target();
        done[9] = 1'b1;
        @(negedge clk);
        check("rst_restart_addr", 32'(readaddr), 32'h24);
        wait_clear(seen, 20);
        check("rst_restart_clear", seen, 32'h200);
        done[9] = 1'b0;
        @(negedge clk);
        check("rst_restart_count", 32'(checked_count), 32'd1);
        check("rst_restart_index", 32'(match_index), 32'd9);
        drain();

        // All 32 slots done, all matching, no pops
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        write_target();
        for (int s = 0; s < 32; s++) set_digest(s, 4'b0000);
        done    = 32'hFFFF_FFFF;
        cyc     = 0;
        nclr    = 0;
        first32 = 0;
        while (first32 == 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (clear != 0) begin
                check("all_order", clear, 32'd1 << nclr);
                if (nclr == 4) check("all_ovf_before", 32'(overflow), 32'd0);
                if (nclr == 5) check("all_ovf_after", 32'(overflow), 32'd1);
                nclr++;
            end
            if (checked_count == 16'd32) first32 = cyc;
        end
        check("all_cycles", 32'(first32), 32'd192);
        check("all_nclr", 32'(nclr), 32'd32);
        expect_no_clear("all_no_recheck", 10);
        for (int k = 0; k < 4; k++) begin
            check("all_fifo_index", 32'(match_index), 32'(k));
            match_pop = 1'b1;
            @(negedge clk);
            match_pop = 1'b0;
        end
        check("all_fifo_empty", 32'(match_empty), 32'd1);
        done = '0;
        @(negedge clk);

        // Randomized batches against the queue model
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        write_target();
        exp_cnt   = 0;
        exp_ovf   = 0;
        last_head = 0;
        rr        = 0;
        q_model.delete();
        for (int b = 0; b < 25; b++) begin
            mask = $urandom() & $urandom() & $urandom();
            if (mask == 0) mask = 32'd1 << $urandom_range(0, 31);
            pop_prob = int'($urandom_range(0, 4));
            exp_order.delete();
            for (int k = 0; k < 32; k++) begin
                int s;
                s = (rr + k) % 32;
                if (mask[s]) begin
                    is_match[s] = ($urandom_range(0, 1) == 1);
                    set_digest(s, is_match[s] ? 4'b0000 : 4'($urandom_range(1, 15)));
                    exp_order.push_back(s);
                    last = s;
                end
            end
            rr     = (last + 1) % 32;
            budget = 6 * exp_order.size() + 20;
            done   = mask;
            for (int c = 0; c < budget && exp_order.size() > 0; c++) rand_cycle();
            check("rnd_batch_complete", 32'(exp_order.size()), 32'd0);
            exp_order.delete();
            done = '0;
            rand_cycle();
            pop_prob = 0;
            rand_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
